execute: RTL and testbench

- Execute (EX) stage of the team's 5-stage 32-bit pipeline, sitting between the decode/ID-EX register and the memory stage.
- Selects operands with forwarding, runs the ALU, and resolves branches and jumps into a next-PC.
- Contains a small multiply-accumulate (matrix) unit.
- All mem-stage outputs leave through an internal EX/MEM register that supports stall and flush. Hazard outputs are combinational.

---
 rtl/execute.sv | 183 ++++++++++++++++++
 tb/tb_execute.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// ============================================================================
// execute : EX stage - forwarding, ALU, branch resolution, MAC, EX/MEM register
// Revision : 1.0
// ============================================================================
`default_nettype none

module execute (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [31:0] read_data1_i,
    input  logic [31:0] read_data2_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] forward_data_i,
    input  logic [1:0]  forward_en_i,
    input  logic [31:0] pc_i,
    input  logic [3:0]  alu_op_i,
    input  logic        imm_sel_i,
    input  logic        wb_sel_i,
    input  logic        reg_write_enable_i,
    input  logic        mem_write_enable_i,
    input  logic [1:0]  branch_type_i,
    input  logic [4:0]  write_reg_sel_i,
    input  logic [4:0]  col_i,
    input  logic [4:0]  row_i,
    input  logic        start_i,
    input  logic        write_enable_A_i,
    input  logic        write_enable_B_i,
    input  logic        write_enable_C_i,
    output logic [31:0] result_o,
    output logic        wb_sel_o,
    output logic        reg_write_enable_o,
    output logic        mem_write_enable_o,
    output logic [4:0]  write_reg_sel_o,
    output logic [31:0] pc_o,
    output logic [31:0] cout_o,
    output logic [31:0] read_data2_o,
    output logic [4:0]  e_dest_reg_o,
    output logic        e_dest_reg_en_o,
    output logic        e_valid_o
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_LUI = 4'b1011;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [3:0] OP_BNE = 4'b1101;
    localparam logic [3:0] OP_BGT = 4'b1110;
    localparam logic [3:0] OP_BLT = 4'b1111;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JUMP = 2'b10;
    localparam logic [1:0] BR_JREG = 2'b11;

    logic [31:0] op_a;
    logic [31:0] rs2_val;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [31:0] next_pc;
    logic [31:0] branch_target;
    logic        taken;
    logic [31:0] mac_a;
    logic [31:0] mac_b;
    logic [31:0] mac_c;
    logic        unused_matrix_idx;

    // Matrix indices are reserved for a later revision.
    assign unused_matrix_idx = ^{col_i, row_i};

    assign op_a    = forward_en_i[0] ? forward_data_i : read_data1_i;
    assign rs2_val = forward_en_i[1] ? forward_data_i : read_data2_i;
    assign op_b    = imm_sel_i ? imm_i : rs2_val;

    always_comb begin
        alu_result = 32'd0;
        case (alu_op_i)
            OP_ADD: alu_result = op_a + op_b;
            OP_SUB: alu_result = op_a - op_b;
            OP_XOR: alu_result = op_a ^ op_b;
            OP_OR:  alu_result = op_a | op_b;
            OP_AND: alu_result = op_a & op_b;
            OP_SLL: alu_result = op_a << op_b[4:0];
            OP_SRL: alu_result = op_a >> op_b[4:0];
            OP_SRA: alu_result = $signed(op_a) >>> op_b[4:0];
            OP_SLT: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_MUL: alu_result = op_a * op_b;
            OP_LUI: alu_result = op_b << 12;
            default: alu_result = 32'd0;
        endcase
    end

    assign branch_target = pc_i + imm_i;

    always_comb begin
        taken = 1'b0;
        case (alu_op_i)
            OP_BEQ: taken = (op_a == op_b);
            OP_BNE: taken = (op_a != op_b);
            OP_BGT: taken = ($signed(op_a) > $signed(op_b));
            OP_BLT: taken = ($signed(op_a) < $signed(op_b));
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc_i;
        case (branch_type_i)
            BR_NONE: next_pc = pc_i;
            BR_COND: next_pc = taken ? branch_target : pc_i;
            BR_JUMP: next_pc = branch_target;
            BR_JREG: next_pc = op_a;
            default: next_pc = pc_i;
        endcase
    end

    assign e_dest_reg_o    = write_reg_sel_i;
    assign e_dest_reg_en_o = reg_write_enable_i;
    assign e_valid_o       = reg_write_enable_i & ~wb_sel_i & ~flush_i;

    // A flushed slot keeps pc_o tracking pc_i so nothing gets redirected.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_o           <= 32'd0;
            wb_sel_o           <= 1'b0;
            reg_write_enable_o <= 1'b0;
            mem_write_enable_o <= 1'b0;
            write_reg_sel_o    <= 5'd0;
            pc_o               <= 32'd0;
            read_data2_o       <= 32'd0;
        end else if (flush_i) begin
            result_o           <= 32'd0;
            wb_sel_o           <= 1'b0;
            reg_write_enable_o <= 1'b0;
            mem_write_enable_o <= 1'b0;
            write_reg_sel_o    <= 5'd0;
            pc_o               <= pc_i;
            read_data2_o       <= 32'd0;
        end else if (!stall_i) begin
            result_o           <= alu_result;
            wb_sel_o           <= wb_sel_i;
            reg_write_enable_o <= reg_write_enable_i;
            mem_write_enable_o <= mem_write_enable_i;
            write_reg_sel_o    <= write_reg_sel_i;
            pc_o               <= next_pc;
            read_data2_o       <= rs2_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mac_a <= 32'd0;
            mac_b <= 32'd0;
            mac_c <= 32'd0;
        end else if (!stall_i && !flush_i) begin
            if (write_enable_A_i) begin
                mac_a <= op_a;
            end
            if (write_enable_B_i) begin
                mac_b <= rs2_val;
            end
            if (write_enable_C_i) begin
                mac_c <= op_a;
            end else if (start_i) begin
                mac_c <= mac_c + mac_a * mac_b;
            end
        end
    end

    assign cout_o = mac_c;

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
// ============================================================================
// tb_execute : directed + randomized self-checking bench for execute
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_execute;

    logic        clk;
    logic        rst_n;
    logic        flush, stall;
    logic [31:0] rd1, rd2, imm, fwd_data, pc;
    logic [1:0]  fwd_en, btype;
    logic [3:0]  alu_op;
    logic        imm_sel, wb_sel, rwe, mwe;
    logic [4:0]  wrs, col, row;
    logic        start, we_a, we_b, we_c;

    logic [31:0] result_o, pc_o, cout_o, rd2_o;
    logic        wb_sel_o, rwe_o, mwe_o, e_dest_en_o, e_valid_o;
    logic [4:0]  wrs_o, e_dest_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_result, m_pc, m_rd2, m_a, m_b, m_c;
    logic        m_wb, m_rwe, m_mwe;
    logic [4:0]  m_wrs;

    execute dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall),
        .read_data1_i(rd1), .read_data2_i(rd2), .imm_i(imm),
        .forward_data_i(fwd_data), .forward_en_i(fwd_en), .pc_i(pc),
        .alu_op_i(alu_op), .imm_sel_i(imm_sel), .wb_sel_i(wb_sel),
        .reg_write_enable_i(rwe), .mem_write_enable_i(mwe),
        .branch_type_i(btype), .write_reg_sel_i(wrs), .col_i(col), .row_i(row),
        .start_i(start), .write_enable_A_i(we_a), .write_enable_B_i(we_b),
        .write_enable_C_i(we_c),
        .result_o(result_o), .wb_sel_o(wb_sel_o), .reg_write_enable_o(rwe_o),
        .mem_write_enable_o(mwe_o), .write_reg_sel_o(wrs_o), .pc_o(pc_o),
        .cout_o(cout_o), .read_data2_o(rd2_o), .e_dest_reg_o(e_dest_o),
        .e_dest_reg_en_o(e_dest_en_o), .e_valid_o(e_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] prod;
        sa = $signed(a);
        sb = $signed(b);
        prod = 64'(sa * sb);
        case (op)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a ^ b;
            4'd4:  return a | b;
            4'd5:  return a & b;
            4'd6:  return a << b[4:0];
            4'd7:  return a >> b[4:0];
            4'd8:  return 32'(sa >>> b[4:0]);
            4'd9:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd10: return prod[31:0];
            4'd11: return b << 12;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_pc(input logic [1:0] bt, input logic [3:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] p, input logic [31:0] im);
        longint sa, sb;
        bit t;
        sa = $signed(a);
        sb = $signed(b);
        t = (op == 4'd12 && sa == sb) || (op == 4'd13 && sa != sb) ||
            (op == 4'd14 && sa > sb)  || (op == 4'd15 && sa < sb);
        if (bt == 2'd1) return t ? p + im : p;
        if (bt == 2'd2) return p + im;
        if (bt == 2'd3) return a;
        return p;
    endfunction

    task automatic idle();
        flush = 0; stall = 0; rd1 = 0; rd2 = 0; imm = 0; fwd_data = 0; fwd_en = 0;
        pc = 0; alu_op = 0; imm_sel = 0; wb_sel = 0; rwe = 0; mwe = 0; btype = 0;
        wrs = 0; col = 0; row = 0; start = 0; we_a = 0; we_b = 0; we_c = 0;
    endtask

    task automatic model_reset();
        m_result = 0; m_pc = 0; m_rd2 = 0; m_a = 0; m_b = 0; m_c = 0;
        m_wb = 0; m_rwe = 0; m_mwe = 0; m_wrs = 0;
    endtask

    // Apply one clock with the current inputs, advancing the model alongside.
    task automatic cycle();
        logic [31:0] a, r2, b;
        logic [63:0] p;
        #1;
        check("e_dest", {27'd0, e_dest_o}, {27'd0, wrs});
        check("e_dest_en", {31'd0, e_dest_en_o}, {31'd0, rwe});
        check("e_valid", {31'd0, e_valid_o}, {31'd0, rwe && !wb_sel && !flush});
        a  = fwd_en[0] ? fwd_data : rd1;
        r2 = fwd_en[1] ? fwd_data : rd2;
        b  = imm_sel ? imm : r2;
        if (flush) begin
            m_result = 0; m_wb = 0; m_rwe = 0; m_mwe = 0; m_wrs = 0; m_rd2 = 0; m_pc = pc;
        end else if (!stall) begin
            m_result = ref_alu(alu_op, a, b);
            m_wb = wb_sel; m_rwe = rwe; m_mwe = mwe; m_wrs = wrs; m_rd2 = r2;
            m_pc = ref_pc(btype, alu_op, a, b, pc, imm);
            p = m_a * m_b;
            if (we_c) m_c = a;
            else if (start) m_c = m_c + p[31:0];
            if (we_a) m_a = a;
            if (we_b) m_b = r2;
        end
        @(posedge clk);
        #1;
        check("result", result_o, m_result);
        check("wb_sel", {31'd0, wb_sel_o}, {31'd0, m_wb});
        check("rwe", {31'd0, rwe_o}, {31'd0, m_rwe});
        check("mwe", {31'd0, mwe_o}, {31'd0, m_mwe});
        check("wrs", {27'd0, wrs_o}, {27'd0, m_wrs});
        check("pc", pc_o, m_pc);
        check("rd2", rd2_o, m_rd2);
        check("cout", cout_o, m_c);
    endtask

    task automatic alu_case(input logic [3:0] op, input logic [31:0] exp, input string tag);
        idle(); rd1 = -32'sd8; rd2 = 32'd3; alu_op = op;
        cycle();
        check(tag, result_o, exp);
    endtask

    task automatic br_case(input logic [1:0] bt, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input string tag);
        idle(); pc = 32'h100; imm = 32'h20; btype = bt; alu_op = op; rd1 = a; rd2 = b;
        cycle();
        check(tag, pc_o, exp);
    endtask

    initial begin
        idle();
        rst_n = 0;
        pc = 32'h1234;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_pc", pc_o, 32'd0);
        check("rst_rwe", {31'd0, rwe_o}, 32'd0);
        check("rst_mwe", {31'd0, mwe_o}, 32'd0);
        check("rst_cout", cout_o, 32'd0);
        #3 rst_n = 1;
        @(posedge clk); #1;

        alu_case(4'd1,  32'hFFFF_FFFB, "alu_add");
        alu_case(4'd2,  32'hFFFF_FFF5, "alu_sub");
        alu_case(4'd8,  32'hFFFF_FFFF, "alu_sra");
        alu_case(4'd7,  32'h1FFF_FFFF, "alu_srl");
        alu_case(4'd9,  32'd1,         "alu_slt");
        alu_case(4'd10, 32'hFFFF_FFE8, "alu_mul");
        idle(); imm_sel = 1; imm = 5; alu_op = 4'd11;
        cycle();
        check("alu_lui", result_o, 32'h5000);

        br_case(2'd1, 4'd12, 7, 7, 32'h120, "beq");
        br_case(2'd1, 4'd13, 7, 7, 32'h100, "bne");
        br_case(2'd1, 4'd15, 32'hFFFF_FFFF, 1, 32'h120, "blt");
        br_case(2'd3, 4'd0, 32'h400, 0, 32'h400, "jr");
        br_case(2'd1, 4'd1, 7, 7, 32'h100, "cond_nonbr");

        idle(); fwd_en = 2'b11; fwd_data = 9; alu_op = 4'd1;
        cycle();
        check("fwd_result", result_o, 32'd18);
        check("fwd_rd2", rd2_o, 32'd9);

        idle(); stall = 1; rd1 = 100; rd2 = 50; alu_op = 4'd1; rwe = 1; wrs = 5'd7;
        pc = 32'h300; btype = 2'd2; imm = 4;
        cycle();
        check("stall_result", result_o, 32'd18);
        check("stall_rd2", rd2_o, 32'd9);
        check("stall_rwe", {31'd0, rwe_o}, 32'd0);

        idle(); flush = 1; btype = 2'd2; pc = 32'h200; imm = 32'h40; rwe = 1; mwe = 1;
        cycle();
        check("flush_pc", pc_o, 32'h200);
        check("flush_rwe", {31'd0, rwe_o}, 32'd0);
        check("flush_mwe", {31'd0, mwe_o}, 32'd0);

        idle(); we_a = 1; rd1 = 3; we_b = 1; rd2 = 4;
        cycle();
        idle(); we_c = 1; rd1 = 1;
        cycle();
        idle(); start = 1;
        cycle();
        check("mac_1", cout_o, 32'd13);
        cycle();
        check("mac_2", cout_o, 32'd25);
        stall = 1;
        cycle();
        check("mac_stall", cout_o, 32'd25);

        for (int i = 0; i < 400; i++) begin
            idle();
            flush    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            rd1      = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rd2      = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            imm      = $urandom;
            fwd_data = $urandom;
            fwd_en   = 2'($urandom);
            pc       = $urandom;
            alu_op   = 4'($urandom);
            imm_sel  = 1'($urandom);
            wb_sel   = 1'($urandom);
            rwe      = 1'($urandom);
            mwe      = 1'($urandom);
            btype    = 2'($urandom);
            wrs      = 5'($urandom);
            col      = 5'($urandom);
            row      = 5'($urandom);
            start    = 1'($urandom);
            we_a     = ($urandom_range(0, 3) == 0);
            we_b     = ($urandom_range(0, 3) == 0);
            we_c     = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
